// File: rtl/cmd_proc_rx.sv
// Receive-side frame parser for the 16-bit GTX command link.
// Hunts for SOP between comma words, captures the header, streams the payload,
// then validates checksum and EOP before reporting a good frame or an error.
//
// state | meaning
// ------+-------------------------------------------------
// HUNT  | idle, waiting for first SOP word 0x2410
// SOP2  | waiting for second SOP word 0x1984
// SEQ   | capturing sequence number
// OPC   | capturing opcode
// LEN   | capturing length, range-checked against MAX_LEN
// DATA  | streaming payload words
// CSUM  | checksum word, compared when CHKSUM_EN is set
// EOP1  | expecting 0xDBEF
// EOP2  | expecting 0xE67B, commits header on match
module cmd_proc_rx #(
  parameter int MAX_LEN   = 16,
  parameter bit CHKSUM_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] RX_DATA,
  input  logic [1:0]  RXCTRL,
  output logic [15:0] PLD_DATA,
  output logic        PLD_VALID,
  output logic [7:0]  PLD_INDEX,
  output logic [15:0] FRM_SEQ,
  output logic [15:0] FRM_OPCODE,
  output logic [15:0] FRM_LEN,
  output logic        FRM_DONE,
  output logic        FRM_ERR,
  output logic [2:0]  ERR_CODE
);

  typedef enum logic [3:0] {
    HUNT, SOP2, SEQ, OPC, LEN, DATA, CSUM, EOP1, EOP2
  } state_t;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] opc_q, opc_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] pld_data_q, pld_data_d;
  logic        pld_valid_q, pld_valid_d;
  logic [7:0]  pld_index_q, pld_index_d;
  logic [15:0] frm_seq_q, frm_seq_d;
  logic [15:0] frm_opc_q, frm_opc_d;
  logic [15:0] frm_len_q, frm_len_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;

  logic is_data;
  logic mid_frame;

  assign is_data   = (RXCTRL == 2'b00);
  assign mid_frame = (state_q != HUNT) && (state_q != SOP2);

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      sum_q       <= '0;
      seq_q       <= '0;
      opc_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pld_data_q  <= '0;
      pld_valid_q <= 1'b0;
      pld_index_q <= '0;
      frm_seq_q   <= '0;
      frm_opc_q   <= '0;
      frm_len_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      seq_q       <= seq_d;
      opc_q       <= opc_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      pld_data_q  <= pld_data_d;
      pld_valid_q <= pld_valid_d;
      pld_index_q <= pld_index_d;
      frm_seq_q   <= frm_seq_d;
      frm_opc_q   <= frm_opc_d;
      frm_len_q   <= frm_len_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Next-state and registered-output decode for the current word.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    seq_d       = seq_q;
    opc_d       = opc_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    pld_data_d  = pld_data_q;
    pld_valid_d = 1'b0;
    pld_index_d = pld_index_q;
    frm_seq_d   = frm_seq_q;
    frm_opc_d   = frm_opc_q;
    frm_len_d   = frm_len_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    // A ctrl word mid-frame outranks every other error cause.
    if (mid_frame && !is_data) begin
      err_d      = 1'b1;
      err_code_d = 3'd1;
      state_d    = HUNT;
    end else begin
      case (state_q)
        HUNT: begin
          if (is_data && RX_DATA == 16'h2410) state_d = SOP2;
        end
        SOP2: begin
          if (is_data && RX_DATA == 16'h1984) begin
            state_d = SEQ;
            sum_d   = '0;
          end else if (!(is_data && RX_DATA == 16'h2410)) begin
            state_d = HUNT;
          end
        end
        SEQ: begin
          seq_d   = RX_DATA;
          sum_d   = sum_q + RX_DATA;
          state_d = OPC;
        end
        OPC: begin
          opc_d   = RX_DATA;
          sum_d   = sum_q + RX_DATA;
          state_d = LEN;
        end
        LEN: begin
          len_d = RX_DATA;
          sum_d = sum_q + RX_DATA;
          cnt_d = '0;
          if (RX_DATA > MAX_LEN_W) begin
            err_d      = 1'b1;
            err_code_d = 3'd2;
            state_d    = HUNT;
          end else if (RX_DATA == 16'h0000) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          sum_d       = sum_q + RX_DATA;
          pld_data_d  = RX_DATA;
          pld_index_d = cnt_q;
          pld_valid_d = 1'b1;
          cnt_d       = cnt_q + 8'd1;
          if (cnt_q == len_q[7:0] - 8'd1) state_d = CSUM;
        end
        CSUM: begin
          if (CHKSUM_EN && RX_DATA != sum_q) begin
            err_d      = 1'b1;
            err_code_d = 3'd3;
            state_d    = HUNT;
          end else begin
            state_d = EOP1;
          end
        end
        EOP1: begin
          if (RX_DATA == 16'hDBEF) begin
            state_d = EOP2;
          end else begin
            err_d      = 1'b1;
            err_code_d = 3'd4;
            state_d    = HUNT;
          end
        end
        EOP2: begin
          state_d = HUNT;
          if (RX_DATA == 16'hE67B) begin
            frm_seq_d = seq_q;
            frm_opc_d = opc_q;
            frm_len_d = len_q;
            done_d    = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = 3'd4;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign PLD_DATA   = pld_data_q;
  assign PLD_VALID  = pld_valid_q;
  assign PLD_INDEX  = pld_index_q;
  assign FRM_SEQ    = frm_seq_q;
  assign FRM_OPCODE = frm_opc_q;
  assign FRM_LEN    = frm_len_q;
  assign FRM_DONE   = done_q;
  assign FRM_ERR    = err_q;
  assign ERR_CODE   = err_code_q;

endmodule

// File: tb/tb_cmd_proc_rx.sv
// Directed bench for cmd_proc_rx. Instance a ignores the checksum word,
// instance b checks it; both see the same word stream.
module tb_cmd_proc_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rx_data = 16'h02bc;
  logic [1:0]  rxctrl  = 2'b01;

  logic [15:0] pld_data_a, pld_data_b, seq_a, seq_b, opc_a, opc_b, len_a, len_b;
  logic [7:0]  pld_idx_a, pld_idx_b;
  logic        pld_v_a, pld_v_b, done_a, done_b, err_a, err_b;
  logic [2:0]  code_a, code_b;

  int n_vec  = 0;
  int n_miss = 0;
  int n_done_a = 0, n_done_b = 0, n_err_a = 0, n_err_b = 0, n_pld_a = 0, n_pld_b = 0;

  always #5 clk = ~clk;

  cmd_proc_rx #(.MAX_LEN(16), .CHKSUM_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .RX_DATA(rx_data), .RXCTRL(rxctrl),
    .PLD_DATA(pld_data_a), .PLD_VALID(pld_v_a), .PLD_INDEX(pld_idx_a),
    .FRM_SEQ(seq_a), .FRM_OPCODE(opc_a), .FRM_LEN(len_a),
    .FRM_DONE(done_a), .FRM_ERR(err_a), .ERR_CODE(code_a)
  );

  cmd_proc_rx #(.MAX_LEN(16), .CHKSUM_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .RX_DATA(rx_data), .RXCTRL(rxctrl),
    .PLD_DATA(pld_data_b), .PLD_VALID(pld_v_b), .PLD_INDEX(pld_idx_b),
    .FRM_SEQ(seq_b), .FRM_OPCODE(opc_b), .FRM_LEN(len_b),
    .FRM_DONE(done_b), .FRM_ERR(err_b), .ERR_CODE(code_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word, let the edge sample it, then look at the registered outputs.
  task automatic send(input logic [15:0] w, input logic [1:0] c);
    rx_data = w;
    rxctrl  = c;
    @(posedge clk);
    #1;
    n_done_a += int'(done_a);
    n_done_b += int'(done_b);
    n_err_a  += int'(err_a);
    n_err_b  += int'(err_b);
    n_pld_a  += int'(pld_v_a);
    n_pld_b  += int'(pld_v_b);
    if (done_a && err_a) chk("excl_a", 32'd1, 32'd0);
    if (done_b && err_b) chk("excl_b", 32'd1, 32'd0);
  endtask

  task automatic dw(input logic [15:0] w);
    send(w, 2'b00);
  endtask

  task automatic idle();
    send(16'h02bc, 2'b01);
  endtask

  initial begin
    int p;
    int d;
    int e;
    // reset
    rst = 1'b1;
    idle();
    idle();
    chk("rst_pld_data", {16'h0, pld_data_a}, 32'h0);
    chk("rst_pld_valid", {31'h0, pld_v_b}, 32'h0);
    chk("rst_pld_index", {24'h0, pld_idx_a}, 32'h0);
    chk("rst_frm_len", {16'h0, len_b}, 32'h0);
    chk("rst_done_err", {30'h0, done_a, err_b}, 32'h0);
    chk("rst_err_code", {29'h0, code_a}, 32'h0);
    rst = 1'b0;
    n_done_a = 0; n_done_b = 0; n_err_a = 0; n_err_b = 0; n_pld_a = 0; n_pld_b = 0;

    // 1: minimal frame, checksum word 0 while true sum is 2
    repeat (4) idle();
    dw(16'h2410); dw(16'h1984); dw(16'h0000); dw(16'h0000); dw(16'h0001);
    dw(16'h0001);
    chk("t1_pld_valid", {31'h0, pld_v_a}, 32'h1);
    chk("t1_pld_data", {16'h0, pld_data_a}, 32'h0001);
    chk("t1_pld_index", {24'h0, pld_idx_a}, 32'h0);
    dw(16'h0000);
    chk("t1_csum_err_b", {28'h0, err_b, code_b}, {28'h0, 1'b1, 3'd3});
    chk("t1_no_err_a", {31'h0, err_a}, 32'h0);
    dw(16'hDBEF);
    chk("t1_no_done_early", {31'h0, done_a}, 32'h0);
    dw(16'hE67B);
    chk("t1_done_a", {31'h0, done_a}, 32'h1);
    chk("t1_len_a", {16'h0, len_a}, 32'h0001);
    chk("t1_done_b", {31'h0, done_b}, 32'h0);
    idle();
    chk("t1_done_pulse", {31'h0, done_a}, 32'h0);
    chk("t1_err_cnt_a", n_err_a, 32'd0);
    chk("t1_pld_cnt_a", n_pld_a, 32'd1);

    // 2: checksum-checked frame, good then bad
    dw(16'h2410); dw(16'h1984); dw(16'h0005); dw(16'h0003); dw(16'h0002);
    dw(16'h0010); dw(16'h0020);
    chk("t2_pld_index1", {24'h0, pld_idx_b}, 32'h1);
    chk("t2_pld_data1", {16'h0, pld_data_b}, 32'h0020);
    dw(16'h003A); dw(16'hDBEF); dw(16'hE67B);
    chk("t2_done_both", {30'h0, done_a, done_b}, 32'h3);
    chk("t2_seq_b", {16'h0, seq_b}, 32'h0005);
    chk("t2_opc_b", {16'h0, opc_b}, 32'h0003);
    chk("t2_len_b", {16'h0, len_b}, 32'h0002);
    dw(16'h2410); dw(16'h1984); dw(16'h0006); dw(16'h0003); dw(16'h0002);
    dw(16'h0010); dw(16'h0020); dw(16'h003A);
    chk("t2_bad_csum_b", {28'h0, err_b, code_b}, {28'h0, 1'b1, 3'd3});
    dw(16'hDBEF); dw(16'hE67B);
    chk("t2_seq_b_held", {16'h0, seq_b}, 32'h0005);
    chk("t2_seq_a_new", {16'h0, seq_a}, 32'h0006);
    chk("t2_done_ab", {30'h0, done_a, done_b}, 32'h2);
    idle();
    chk("t2_code_held", {29'h0, code_b}, 32'd3);

    // 3: oversize length, then a normal frame
    dw(16'h2410); dw(16'h1984); dw(16'h0007); dw(16'h0001);
    dw(16'h0011);
    chk("t3_len_err_a", {28'h0, err_a, code_a}, {28'h0, 1'b1, 3'd2});
    chk("t3_len_err_b", {28'h0, err_b, code_b}, {28'h0, 1'b1, 3'd2});
    dw(16'h0000); idle();
    chk("t3_err_pulse", {31'h0, err_b}, 32'h0);
    dw(16'h2410); dw(16'h1984); dw(16'h0008); dw(16'h0002); dw(16'h0001);
    dw(16'hABCD); dw(16'hABD8); dw(16'hDBEF); dw(16'hE67B);
    chk("t3_done_both", {30'h0, done_a, done_b}, 32'h3);
    chk("t3_seq_b", {16'h0, seq_b}, 32'h0008);
    chk("t3_len_b", {16'h0, len_b}, 32'h0001);

    // 4: comma injected mid-payload
    dw(16'h2410); dw(16'h1984); dw(16'h0009); dw(16'h0001); dw(16'h0003);
    dw(16'h1111);
    chk("t4_pld_v", {31'h0, pld_v_b}, 32'h1);
    p = n_pld_b;
    idle();
    chk("t4_ctrl_err", {28'h0, err_b, code_b}, {28'h0, 1'b1, 3'd1});
    dw(16'h2222); dw(16'h3333);
    chk("t4_no_more_pld", n_pld_b, p);

    // ctrl word in LEN with an oversize value: ctrl error wins
    dw(16'h2410); dw(16'h1984); dw(16'h0001); dw(16'h0001);
    send(16'h0011, 2'b10);
    chk("t4_prio", {28'h0, err_a, code_a}, {28'h0, 1'b1, 3'd1});

    // 5: EOP errors, repeated SOP1, aborted SOP
    dw(16'h2410); dw(16'h1984); dw(16'h000A); dw(16'h0000); dw(16'h0000);
    dw(16'h000A); dw(16'hDBEF); dw(16'hE67C);
    chk("t5_eop2_err", {28'h0, err_b, code_b}, {28'h0, 1'b1, 3'd4});
    dw(16'h2410); dw(16'h1984); dw(16'h000D); dw(16'h0000); dw(16'h0000);
    dw(16'h000D); dw(16'hDBEE);
    chk("t5_eop1_err", {28'h0, err_a, code_a}, {28'h0, 1'b1, 3'd4});
    dw(16'h2410); dw(16'h2410); dw(16'h1984); dw(16'h000B); dw(16'h0000);
    dw(16'h0000); dw(16'h000B); dw(16'hDBEF); dw(16'hE67B);
    chk("t5_resync_done", {30'h0, done_a, done_b}, 32'h3);
    chk("t5_resync_seq", {16'h0, seq_b}, 32'h000B);
    chk("t5_len0", {16'h0, len_a}, 32'h0000);
    d = n_done_b;
    e = n_err_b;
    dw(16'h2410); dw(16'h1234);
    dw(16'h1984); dw(16'h000C); dw(16'h0000); dw(16'h0000); dw(16'h000C);
    dw(16'hDBEF); dw(16'hE67B);
    chk("t5_silent_done", n_done_b, d);
    chk("t5_silent_err", n_err_b, e);

    // 6: back-to-back frames, then reset mid-payload
    d = n_done_a;
    dw(16'h2410); dw(16'h1984); dw(16'h0020); dw(16'h0001); dw(16'h0001);
    dw(16'h0005); dw(16'h0027); dw(16'hDBEF); dw(16'hE67B);
    chk("t6_done1", {30'h0, done_a, done_b}, 32'h3);
    dw(16'h2410);
    chk("t6_seq1", {16'h0, seq_b}, 32'h0020);
    dw(16'h1984); dw(16'h0021); dw(16'h0001); dw(16'h0001);
    dw(16'h0006); dw(16'h0029); dw(16'hDBEF); dw(16'hE67B);
    chk("t6_done2", {30'h0, done_a, done_b}, 32'h3);
    chk("t6_seq2", {16'h0, seq_b}, 32'h0021);
    chk("t6_done_cnt", n_done_a - d, 32'd2);
    e = n_err_a + n_err_b;
    dw(16'h2410); dw(16'h1984); dw(16'h0030); dw(16'h0001); dw(16'h0002);
    dw(16'h0001);
    chk("t6_pld_pre_rst", {31'h0, pld_v_a}, 32'h1);
    rst = 1'b1;
    dw(16'h0002);
    chk("t6_rst_outs_a", {pld_data_a, pld_idx_a, 1'b0, pld_v_a, done_a, err_a, 1'b0, code_a}, 32'h0);
    chk("t6_rst_hdr_b", {seq_b, opc_b | len_b}, 32'h0);
    rst = 1'b0;
    dw(16'h0003); dw(16'hDBEF); dw(16'hE67B); idle(); idle();
    chk("t6_no_err_after_rst", (n_err_a + n_err_b) - e, 32'd0);
    chk("t6_hdr_after_rst", {16'h0, seq_a}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
